// File: rtl/uart_rx_core.sv
// UART receive core: oversampled, majority-voted serial line decoder with
// optional even/odd parity and one-cycle result pulses.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int EW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
  localparam logic [EW-1:0] EDGE_S0   = EW'(OVERSAMPLE / 2 - 1);
  localparam logic [EW-1:0] EDGE_S1   = EW'(OVERSAMPLE / 2);
  localparam logic [EW-1:0] EDGE_S2   = EW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [2:0]            samp_q, samp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_fail_q, par_fail_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic                  maj;
  logic                  last_edge;

  assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign last_edge = (edge_q == EDGE_LAST);

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_fail_d = par_fail_q;
    pdata_d    = pdata_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    // Edge counter and sample windows run identically in every in-frame state.
    if (state_q != S_IDLE) begin
      edge_d = last_edge ? '0 : edge_q + 1'b1;
      if (edge_q == EDGE_S0) samp_d[0] = RX_IN;
      if (edge_q == EDGE_S1) samp_d[1] = RX_IN;
      if (edge_q == EDGE_S2) samp_d[2] = RX_IN;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!RX_IN) begin
          state_d    = S_START;
          edge_d     = EW'(1);
          bit_d      = '0;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_fail_d = 1'b0;
        end
      end
      S_START: begin
        if (last_edge) state_d = maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (last_edge) begin
          shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (last_edge) begin
          par_fail_d = (maj != ((^shift_q) ^ par_typ_q));
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (last_edge) begin
          state_d = S_IDLE;
          se_d    = ~maj;
          pe_d    = par_en_q & par_fail_q;
          if (maj && !(par_en_q && par_fail_q)) begin
            pdata_d = shift_q;
            dv_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail_q <= 1'b0;
      pdata_q    <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_fail_q <= par_fail_d;
      pdata_q    <= pdata_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frame table, start glitch, mid-frame reset,
// and randomized frames checked against a waveform-level reference model.
module tb_uart_rx_core;
  localparam int W  = 8;
  localparam int OS = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         RX_IN = 1'b1;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [W-1:0] P_DATA;
  logic         data_valid, par_err, stp_err;

  uart_rx_core #(.DATA_WIDTH(W), .OVERSAMPLE(OS)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] data;
    logic         pen;
    logic         ptyp;
    logic         pbit;
    logic         stop;
    int           glitch;   // frame cycle to invert, -1 for none
    logic [2:0]   exp;      // {data_valid, par_err, stp_err}
  } vec_t;

  int n_chk = 0, n_fail = 0, n_stray = 0, n_pbad = 0;
  logic         pend = 1'b0;
  logic [2:0]   pend_flags;
  logic [W-1:0] pend_data;
  logic [W-1:0] model_pdata = '0;
  logic         wave [0:(W+3)*OS-1];
  int           wlen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: check outputs of the cycle, then drive the inputs it consumes.
  task automatic tick(input logic rx, input logic pen, input logic ptyp);
    @(negedge CLK);
    if (pend) begin
      check("pulse_flags", {29'd0, data_valid, par_err, stp_err}, {29'd0, pend_flags});
      if (pend_flags[2]) model_pdata = pend_data;
      check("p_data", {24'd0, P_DATA}, {24'd0, model_pdata});
      pend = 1'b0;
    end else if (data_valid || par_err || stp_err) begin
      n_stray++;
    end
    if (P_DATA !== model_pdata) n_pbad++;
    RX_IN   = rx;
    PAR_EN  = pen;
    PAR_TYP = ptyp;
  endtask

  task automatic build(input logic [W-1:0] d, input logic pen, input logic pbit,
                       input logic stop, input int glitch);
    int nb;
    logic bits [0:W+2];
    nb = W + 2 + (pen ? 1 : 0);
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[i+1] = d[i];
    if (pen) bits[W+1] = pbit;
    bits[nb-1] = stop;
    wlen = nb * OS;
    for (int c = 0; c < wlen; c++) wave[c] = bits[c / OS];
    if (glitch >= 0) wave[glitch] = ~wave[glitch];
  endtask

  // Majority over the three mid-bit cycles of bit b of the built waveform.
  function automatic logic vote(input int b);
    int s;
    s = 0;
    for (int k = OS/2 - 1; k <= OS/2 + 1; k++) s += wave[b*OS + k] ? 1 : 0;
    return (s >= 2);
  endfunction

  // Receiver expectation from the frame rules, applied to the actual line.
  function automatic logic [2:0] model(input logic pen, input logic ptyp, output logic [W-1:0] d);
    logic se, pe;
    int nb;
    nb = W + 2 + (pen ? 1 : 0);
    for (int i = 0; i < W; i++) d[i] = vote(i + 1);
    se = ~vote(nb - 1);
    pe = pen && (vote(W + 1) != ((^d) ^ ptyp));
    return {~se & ~pe, pe, se};
  endfunction

  task automatic send(input vec_t v);
    for (int c = 0; c < wlen; c++)
      tick(wave[c], (c == 0) ? v.pen : 1'($urandom), (c == 0) ? v.ptyp : 1'($urandom));
    pend       = 1'b1;
    pend_flags = v.exp;
    pend_data  = v.data;
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3'b100};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1, 3'b100};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1, 3'b010};
    tbl[3] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, -1, 3'b001};
    tbl[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 12, 3'b100};
    tbl[5] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, 3'b100};
    tbl[6] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, -1, 3'b011};
    tbl[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 9,  3'b100};
    tbl[8] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3'b100};
    tbl[9] = '{8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3'b100};

    @(negedge CLK);
    check("reset_outputs", {20'd0, P_DATA, data_valid, par_err, stp_err}, 32'd0);
    RST = 1'b1;
    repeat (3) tick(1'b1, 1'b0, 1'b0);

    // Directed table, sent back to back: each start lands in the previous pulse cycle.
    foreach (tbl[i]) begin
      build(tbl[i].data, tbl[i].pen, tbl[i].pbit, tbl[i].stop, tbl[i].glitch);
      send(tbl[i]);
    end
    repeat (4) tick(1'b1, 1'b0, 1'b0);

    // Two-cycle start glitch; a real frame begins at cycle 8.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    repeat (6) tick(1'b1, 1'b0, 1'b0);
    build(8'h96, 1'b0, 1'b0, 1'b1, -1);
    send('{8'h96, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3'b100});
    repeat (2) tick(1'b1, 1'b0, 1'b0);

    // Randomized frames checked against the model.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      logic [W-1:0] md;
      v.data   = W'($urandom);
      v.pen    = 1'($urandom);
      v.ptyp   = 1'($urandom);
      v.pbit   = ((^v.data) ^ v.ptyp) ^ ($urandom_range(3) == 0);
      v.stop   = ($urandom_range(3) != 0);
      build(v.data, v.pen, v.pbit, v.stop, -1);
      v.glitch = ($urandom_range(1) == 1) ? int'($urandom_range(wlen - 1, 1)) : -1;
      build(v.data, v.pen, v.pbit, v.stop, v.glitch);
      v.exp  = model(v.pen, v.ptyp, md);
      v.data = md;
      send(v);
      repeat ($urandom_range(3)) tick(1'b1, 1'($urandom), 1'($urandom));
    end
    repeat (2) tick(1'b1, 1'b0, 1'b0);

    // Reset 40 cycles into a frame, then a clean frame.
    build(8'hC3, 1'b0, 1'b0, 1'b1, -1);
    for (int c = 0; c < 40; c++) tick(wave[c], 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    RX_IN = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("outputs_in_reset", {20'd0, P_DATA, data_valid, par_err, stp_err}, 32'd0);
    end
    RST = 1'b1;
    RX_IN = 1'b1;
    model_pdata = '0;
    repeat (60) tick(1'b1, 1'b0, 1'b0);
    build(8'h0F, 1'b0, 1'b0, 1'b1, -1);
    send('{8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, -1, 3'b100});
    repeat (4) tick(1'b1, 1'b0, 1'b0);

    check("no_stray_pulses", n_stray, 0);
    check("p_data_stable", n_pbad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
